// File: rtl/sub_word_engine_if.sv
`default_nettype none
// sub_word_engine_if: input/output valid-ready channels of the S-box substitution engine.
// Revision 1.0

interface sub_word_engine_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_inv;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  busy;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/sub_word_engine.sv
`default_nettype none
// sub_word_engine: folded AES S-box engine, NUM_SBOX lanes reused over NUM_BYTES bytes.
// Optional inverse S-box lanes built when INV_SBOX_EN is defined.  Revision 1.0

module gf256_inv (
    input  wire logic [7:0] a,
    output logic      [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] acc;
        logic [7:0] t;
        acc = 8'h00;
        t   = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) acc = acc ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as the S-box requires
    always_comb begin : p_pow
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        y = r;
    end
endmodule

module sbox (
    input  wire logic [7:0] din,
    output logic      [7:0] dout
);
    logic [7:0] b;

    gf256_inv u_inv (.a(din), .y(b));

    assign dout = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                    ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module inv_sbox (
    input  wire logic [7:0] din,
    output logic      [7:0] dout
);
    logic [7:0] t;

    assign t = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;

    gf256_inv u_inv (.a(t), .y(dout));
endmodule

module sub_word_engine #(
    parameter int BYTE_SIZE = 8,
    parameter int NUM_BYTES = 4,
    parameter int NUM_SBOX  = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sub_word_engine_if.slave  bus
);
    localparam int PASSES     = NUM_BYTES / NUM_SBOX;
    localparam int DATA_WIDTH = NUM_BYTES * BYTE_SIZE;
    localparam int CNT_W      = (PASSES > 1) ? $clog2(PASSES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   ready;
    logic                   accept;
    logic                   last_pass;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_WIDTH-1:0]  cap_data;
    logic [DATA_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]  acc_next;
    logic [DATA_WIDTH-1:0]  out_reg;
    logic [BYTE_SIZE-1:0]   lane_out [NUM_SBOX];

    assign last_pass = (cnt == CNT_W'(PASSES - 1));
    assign accept    = ready & bus.in_valid;

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last_pass) state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    ready      = 1'b1;
                    state_next = bus.in_valid ? BUSY : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_data <= '0;
            cnt      <= '0;
            acc      <= '0;
            out_reg  <= '0;
        end else if (accept) begin
            cap_data <= bus.in_data;
            cnt      <= '0;
        end else if (state == BUSY) begin
            acc <= acc_next;
            cnt <= last_pass ? '0 : cnt + CNT_W'(1);
            if (last_pass) out_reg <= acc_next;
        end
    end

`ifdef INV_SBOX_EN
    logic cap_inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cap_inv <= 1'b0;
        else if (accept) cap_inv <= bus.in_inv;
    end
`else
    // Forward-only build: the direction request is ignored.
    logic unused_inv;
    assign unused_inv = bus.in_inv;
`endif

    for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
        logic [BYTE_SIZE-1:0] sel;
        logic [BYTE_SIZE-1:0] fwd;

        // Lane l serves byte cnt*NUM_SBOX+l of the captured word
        always_comb begin
            sel = cap_data[DATA_WIDTH-1-l*BYTE_SIZE -: BYTE_SIZE];
            for (int p = 1; p < PASSES; p++) begin
                if (cnt == CNT_W'(p))
                    sel = cap_data[DATA_WIDTH-1-(p*NUM_SBOX+l)*BYTE_SIZE -: BYTE_SIZE];
            end
        end

        sbox u_fwd (.din(sel), .dout(fwd));

`ifdef INV_SBOX_EN
        logic [BYTE_SIZE-1:0] bwd;

        inv_sbox u_bwd (.din(sel), .dout(bwd));

        assign lane_out[l] = cap_inv ? bwd : fwd;
`else
        assign lane_out[l] = fwd;
`endif
    end

    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte
        localparam int PASS = b / NUM_SBOX;
        localparam int LANE = b % NUM_SBOX;

        assign acc_next[DATA_WIDTH-1-b*BYTE_SIZE -: BYTE_SIZE] =
            (cnt == CNT_W'(PASS)) ? lane_out[LANE]
                                  : acc[DATA_WIDTH-1-b*BYTE_SIZE -: BYTE_SIZE];
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == BUSY);
    assign bus.out_data  = out_reg;
endmodule

`default_nettype wire

// File: tb/tb_sub_word_engine.sv
`default_nettype none
// tb_sub_word_engine: table vectors, corner sequences and random streaming against a
// table-lookup AES S-box model; also exercises 16-byte builds with 4, 1 and 16 lanes.

module tb_sub_word_engine;
    localparam int PASSES = 2;
`ifdef INV_SBOX_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sub_word_engine_if #(.DATA_WIDTH(32))  bus ();
    sub_word_engine_if #(.DATA_WIDTH(128)) bus_a ();
    sub_word_engine_if #(.DATA_WIDTH(128)) bus_b ();
    sub_word_engine_if #(.DATA_WIDTH(128)) bus_c ();

    sub_word_engine #(.BYTE_SIZE(8), .NUM_BYTES(4),  .NUM_SBOX(2))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    sub_word_engine #(.BYTE_SIZE(8), .NUM_BYTES(16), .NUM_SBOX(4))  dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    sub_word_engine #(.BYTE_SIZE(8), .NUM_BYTES(16), .NUM_SBOX(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    sub_word_engine #(.BYTE_SIZE(8), .NUM_BYTES(16), .NUM_SBOX(16)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    int checks = 0;
    int errors = 0;
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    typedef struct {
        logic [31:0] data;
        logic        inv;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Classic generator: walk GF(2^8) with generator 3 and its inverse in lockstep
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            fwd_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd_tab[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input int nbytes, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < nbytes; i++)
            r[8*i +: 8] = (inv && INV_EN) ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
        return r;
    endfunction

    // Called right after a negedge; returns edges from acceptance to out_valid
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic inv, output int lat);
        bus.in_data  = d;
        bus.in_inv   = inv;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(lat);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [5];
        int           lat;
        int           lat_a, lat_b, lat_c;
        logic [31:0]  d;
        logic         iv;
        logic [127:0] m;
        logic [127:0] d16;
        logic [31:0]  words [8];
        logic         invs  [8];
        logic [127:0] expq  [$];
        int           k, cyc, nres, last_cyc;
        bit           acc_now;

        build_tables();
        vecs[0] = '{32'hcf4f3c09, 1'b0, 32'h8a84eb01};
        vecs[1] = '{32'h00010253, 1'b0, 32'h637c77ed};
`ifdef INV_SBOX_EN
        vecs[2] = '{32'h637c77ed, 1'b1, 32'h00010253};
`else
        vecs[2] = '{32'h637c77ed, 1'b1, 32'hfb10f555};
`endif
        vecs[3] = '{32'hffffffff, 1'b0, 32'h16161616};
        vecs[4] = '{32'h00000000, 1'b0, 32'h63636363};

        bus.in_valid = 0; bus.in_data = '0; bus.in_inv = 0; bus.out_ready = 0;
        bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.in_inv = 0; bus_a.out_ready = 0;
        bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.in_inv = 0; bus_b.out_ready = 0;
        bus_c.in_valid = 0; bus_c.in_data = '0; bus_c.in_inv = 0; bus_c.out_ready = 0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_out_data",  bus.out_data, 0);
        check("rst_in_ready",  bus.in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            check("vec_in_ready", bus.in_ready, 1);
            send(vecs[i].data, vecs[i].inv, lat);
            check("vec_latency", lat, PASSES);
            check("vec_data", bus.out_data, vecs[i].exp);
            consume();
            check("vec_idle", bus.out_valid, 0);
        end

        // Backpressure: DONE held, new input ignored while out_ready=0
        send(32'h01234567, 1'b0, lat);
        m = model(128'h01234567, 4, 1'b0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.in_data = $urandom;
            @(negedge clk);
            check("bp_data_stable", bus.out_data, m);
            check("bp_in_ready",    bus.in_ready, 0);
            check("bp_out_valid",   bus.out_valid, 1);
        end
        d  = $urandom;
        iv = 1'($urandom_range(0, 1));
        bus.in_data   = d;
        bus.in_inv    = iv;
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("bp_accept_busy", bus.busy, 1);
        wait_out(lat);
        check("bp_latency", lat, PASSES);
        check("bp_data", bus.out_data, model({96'h0, d}, 4, iv));
        consume();

        // Asynchronous reset in the middle of BUSY
        bus.in_data  = 32'hdeadbeef;
        bus.in_inv   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy",      bus.busy, 0);
        check("mid_rst_out_data",  bus.out_data, 0);
        check("mid_rst_in_ready",  bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rst_discard", bus.out_valid, 0);
        check("mid_rst_ready",   bus.in_ready, 1);
        d = $urandom;
        send(d, 1'b0, lat);
        check("post_rst_latency", lat, PASSES);
        check("post_rst_data", bus.out_data, model({96'h0, d}, 4, 1'b0));
        consume();

        // Streaming with both sides always willing
        for (int i = 0; i < 8; i++) begin
            words[i] = $urandom;
            invs[i]  = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
        bus.in_data   = words[0];
        bus.in_inv    = invs[0];
        bus.in_valid  = 1'b1;
        k = 0; cyc = 0; nres = 0; last_cyc = 0;
        while (nres < 8 && cyc < 200) begin
            if (bus.out_valid) begin
                if (expq.size() == 0) check("stream_spurious", bus.out_valid, 0);
                else                  check("stream_data", bus.out_data, expq.pop_front());
                if (nres > 0) check("stream_gap", cyc - last_cyc, PASSES + 1);
                last_cyc = cyc;
                nres++;
            end
            acc_now = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc_now) begin
                expq.push_back(model({96'h0, words[k]}, 4, invs[k]));
                k++;
            end
            @(negedge clk);
            cyc++;
            if (k < 8) begin
                bus.in_data = words[k];
                bus.in_inv  = invs[k];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        check("stream_count", nres, 8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // 16-byte builds with 4, 1 and 16 lanes
        for (int r = 0; r < 2; r++) begin
            d16 = (r == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
            bus_a.in_data = d16; bus_b.in_data = d16; bus_c.in_data = d16;
            bus_a.in_valid = 1; bus_b.in_valid = 1; bus_c.in_valid = 1;
            @(posedge clk);
            @(negedge clk);
            bus_a.in_valid = 0; bus_b.in_valid = 0; bus_c.in_valid = 0;
            lat_a = -1; lat_b = -1; lat_c = -1;
            for (int n = 0; n <= 20; n++) begin
                if (bus_a.out_valid && lat_a < 0) lat_a = n;
                if (bus_b.out_valid && lat_b < 0) lat_b = n;
                if (bus_c.out_valid && lat_c < 0) lat_c = n;
                @(negedge clk);
            end
            m = (r == 0) ? {16{8'h63}} : model(d16, 16, 1'b0);
            check("w16_s4_latency",  lat_a, 4);
            check("w16_s1_latency",  lat_b, 16);
            check("w16_s16_latency", lat_c, 1);
            check("w16_s4_data",  bus_a.out_data, m);
            check("w16_s1_data",  bus_b.out_data, m);
            check("w16_s16_data", bus_c.out_data, m);
            bus_a.out_ready = 1; bus_b.out_ready = 1; bus_c.out_ready = 1;
            @(negedge clk);
            bus_a.out_ready = 0; bus_b.out_ready = 0; bus_c.out_ready = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
